pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer, flush, and a stall-cycle counter. It is the drop-in successor for the fixed-width inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). A global write-enable is replaced by per-stage backpressure, so a stall propagates one stage per cycle without a combinational ready chain. Control bits are forced to zero whenever the stage holds no valid beat, so downstream stages never see a spurious RegWrite, MemWrite or HLT.

## Interface
Parameters:
- DATA_W, 16: payload width (ALU result, PC, store value, etc., concatenated by the instantiating stage)
- CTRL_W, 9: control-bit width (MemRead, MemtoReg, MemWrite, RegWrite, flag-write, HLT, ...)
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready
- CNT_W, 16: stall-counter width

Ports:
- clk, in, 1: clock, rising edge
- rst, in, 1: asynchronous, active-low reset
- flush, in, 1: discard all held beats and any beat offered this cycle
- in_valid, in, 1: upstream beat valid
- in_ready, out, 1: stage can accept a beat
- in_ctrl, in, CTRL_W: upstream control bits
- in_data, in, DATA_W: upstream payload
- out_valid, out, 1: head beat valid
- out_ready, in, 1: downstream accepts the head beat
- out_ctrl, out, CTRL_W: head control bits; all zero when out_valid=0
- out_data, out, DATA_W: head payload; holds its last value when out_valid=0
- stall_cnt, out, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- accept = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- States are EMPTY, ONE and TWO. TWO exists only when SKID=1. The main entry drives out_*; the skid entry is internal.
- From EMPTY:
  - accept: load main, go to ONE.
  - otherwise: stay in EMPTY.
- From ONE:
  - accept & pop: load main with the new beat, stay in ONE.
  - accept & !pop: SKID=1 loads skid and goes to TWO; with SKID=0 this case cannot occur.
  - !accept & pop: go to EMPTY.
  - otherwise: hold.
- From TWO:
  - pop: main <= skid, go to ONE.
  - otherwise: hold. No accept is possible because in_ready=0.
- in_ready:
  - SKID=1: registered; in_ready = (next state != TWO).
  - SKID=0: in_ready = !out_valid | out_ready (combinational).
- flush has highest priority over accept and pop. Next state is EMPTY and the offered beat is dropped. Payload registers keep their contents; only valid and control state are cleared.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}.
- stall_cnt increments when out_valid & !out_ready, saturates at 2^CNT_W-1, and is cleared only by reset.
- Ordering is strict FIFO. Beats are never duplicated or reordered.

## Timing
- Reset (rst=0, asynchronous):
  - state EMPTY, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
  - in_ready=1 for SKID=1. For SKID=0 it follows the combinational rule, which evaluates to 1.
  - All payload registers reset to 0.
- Latency: an accept at edge N gives out_valid=1 at edge N+1.
- Throughput is 1 beat/cycle with out_ready held at 1, for both SKID values.
- SKID=1 backpressure: in_ready deasserts in the cycle after the first beat is captured into the skid entry. Exactly one beat is absorbed after out_ready falls.
- Simultaneous flush & pop: the pop completes downstream as usual (downstream sampled it), and the stage goes to EMPTY.
- A reset asserted mid-transfer drops all beats. The first edge after rst rises may accept a beat.

## Structure
- Shared package pipe_pkg:
  - state enum (ST_EMPTY, ST_ONE, ST_TWO).
  - Per-stage localparam CTRL_W/DATA_W constants for IF_ID, ID_EX, EX_MEM and MEM_WB, so each stage instance is typed consistently.
- Sub-module pipe_entry: a width-parametrised enabled register holding {ctrl, data}. It is instantiated once for main and, under a generate on SKID, once for skid.
- The FSM, handshake logic and counter live in the top-level module.

## Test plan
- Streaming: SKID=1, out_ready=1, beats data 0x0001..0x0008 -> same values out in order, one per cycle, 1-cycle latency, stall_cnt=0.
- Backpressure: SKID=1, in_valid=1 continuously, out_ready low for cycles 3-6 -> in_ready low from cycle 4; no loss or duplication; stall_cnt=4.
- Flush while in TWO: stage holds beats 0xAAAA and 0xBBBB; flush=1 together with in_valid, data 0xCCCC -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xCCCC never emerges.
- Bubble control masking: in_ctrl=0x1FF and in_valid=0 -> out_ctrl stays 0x000 every cycle.
- SKID=0: out_ready=0 with the stage full -> in_ready=0 in the same cycle; with out_ready=1 and in_valid=1 a new beat replaces the head every cycle.
- Async reset mid-stream: pull rst low between edges in state TWO -> out_valid, out_ctrl and stall_cnt read 0 immediately (no clock edge needed). With CNT_W=2 and a held stall, stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and per-stage widths for the inter-stage pipeline registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

   // Occupancy of a stage register: no beat, head only, head plus skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stageState_t;

   // IF/ID: fetched instruction word plus PC; only HLT travels as control.
   localparam int IF_ID_CTRL_W  = 1;
   localparam int IF_ID_DATA_W  = 32;

   // ID/EX: full decoded control set, two operands and the destination/immediate.
   localparam int ID_EX_CTRL_W  = 9;
   localparam int ID_EX_DATA_W  = 48;

   // EX/MEM: memory controls plus writeback controls; ALU result and store value.
   localparam int EX_MEM_CTRL_W = 6;
   localparam int EX_MEM_DATA_W = 32;

   // MEM/WB: writeback controls only; result and destination register index.
   localparam int MEM_WB_CTRL_W = 3;
   localparam int MEM_WB_DATA_W = 20;

   // True when the stage cannot take another beat without a pop.
   function automatic logic isFull(input stageState_t s);
      return (s == ST_TWO);
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of a stage register, holding the concatenated {ctrl, data}.
// Latency: value appears on q one edge after load.
// Backpressure: none; the owner decides when to load.
module pipe_entry #(
   parameter int WIDTH = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture a new beat when loaded; otherwise keep the previous contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid, flush and stall counter.
// Latency: 1 cycle from accept to out_valid; sustains 1 beat/cycle while out_ready stays high.
// Backpressure: SKID=1 registers in_ready and absorbs one beat after out_ready drops; SKID=0 passes out_ready through.
module pipe_stage_reg import pipe_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int CTRL_W = 9,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int ENTRY_W = CTRL_W + DATA_W;

   stageState_t        stateQ;
   stageState_t        stateD;
   logic               headValid;
   logic               accept;
   logic               pop;
   logic               mainLoad;
   logic               mainFromSkid;
   logic               skidLoad;
   logic [ENTRY_W-1:0] inBeat;
   logic [ENTRY_W-1:0] mainNext;
   logic [ENTRY_W-1:0] mainQ;
   logic [ENTRY_W-1:0] skidQ;
   logic [CNT_W-1:0]   stallQ;

   // The head entry is valid in every state except EMPTY.
   assign headValid = (stateQ != ST_EMPTY);

   // A beat offered in the same cycle as flush is dropped, so flush gates accept.
   assign accept = in_valid & in_ready & ~flush;
   assign pop    = headValid & out_ready;

   assign inBeat = {in_ctrl, in_data};

   // Occupancy register; reset empties the stage regardless of any transfer in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ <= ST_EMPTY;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next occupancy and entry-load decisions; flush wins over accept and pop and leaves payloads untouched.
   always_comb begin
      stateD       = stateQ;
      mainLoad     = 1'b0;
      mainFromSkid = 1'b0;
      skidLoad     = 1'b0;
      if (flush) begin
         stateD = ST_EMPTY;
      end else begin
         case (stateQ)
            ST_EMPTY: begin
               if (accept) begin
                  mainLoad = 1'b1;
                  stateD   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  // Head leaves and the new beat takes its place.
                  mainLoad = 1'b1;
               end else if (accept && (SKID != 0)) begin
                  // Head is stuck; park the new beat behind it.
                  skidLoad = 1'b1;
                  stateD   = ST_TWO;
               end else if (pop) begin
                  stateD = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a pop can move things along.
               if (pop) begin
                  mainLoad     = 1'b1;
                  mainFromSkid = 1'b1;
                  stateD       = ST_ONE;
               end
            end
            default: begin
               stateD = ST_EMPTY;
            end
         endcase
      end
   end

   assign mainNext = mainFromSkid ? skidQ : inBeat;

   pipe_entry #(
      .WIDTH (ENTRY_W)
   ) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (mainLoad),
      .d    (mainNext),
      .q    (mainQ)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic readyQ;

         pipe_entry #(
            .WIDTH (ENTRY_W)
         ) u_skid (
            .clk  (clk),
            .rst  (rst),
            .load (skidLoad),
            .d    (inBeat),
            .q    (skidQ)
         );

         // Registered ready: drop it exactly when the stage is about to hold two beats.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               readyQ <= 1'b1;
            end else begin
               readyQ <= ~isFull(stateD);
            end
         end

         assign in_ready = readyQ;
      end else begin : g_noskid
         // Single entry: room exists if empty or if the head leaves this cycle.
         assign skidQ    = '0;
         assign in_ready = ~headValid | out_ready;
      end
   endgenerate

   // Count cycles where the head is offered but refused; saturate instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallQ <= '0;
      end else if (headValid && !out_ready && (stallQ != {CNT_W{1'b1}})) begin
         stallQ <= stallQ + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_valid = headValid;
   // Control bits are masked so an empty stage never asserts RegWrite/MemWrite/HLT downstream.
   assign out_ctrl  = mainQ[ENTRY_W-1 -: CTRL_W] & {CTRL_W{headValid}};
   assign out_data  = mainQ[DATA_W-1:0];
   assign stall_cnt = stallQ;

endmodule
